// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the execute-stage ALU with the
//                iterative multiply/divide unit. It holds the 4-bit ctrl
//                opcode encodings and the mul/div sequencer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ctrl encodings: combinational operations
    localparam logic [3:0] c_op_add   = 4'b0000;
    localparam logic [3:0] c_op_sub   = 4'b0001;
    localparam logic [3:0] c_op_and   = 4'b0010;
    localparam logic [3:0] c_op_or    = 4'b0011;
    localparam logic [3:0] c_op_xor   = 4'b0100;
    localparam logic [3:0] c_op_nor   = 4'b0101;
    localparam logic [3:0] c_op_slt   = 4'b0110;
    localparam logic [3:0] c_op_sltu  = 4'b0111;
    // ctrl encodings: sequential operations, qualified by start
    localparam logic [3:0] c_op_mult  = 4'b1000;
    localparam logic [3:0] c_op_multu = 4'b1001;
    localparam logic [3:0] c_op_div   = 4'b1010;
    localparam logic [3:0] c_op_divu  = 4'b1011;
    // ctrl encodings: HI/LO access
    localparam logic [3:0] c_op_mfhi  = 4'b1100;
    localparam logic [3:0] c_op_mflo  = 4'b1101;
    localparam logic [3:0] c_op_mthi  = 4'b1110;
    localparam logic [3:0] c_op_mtlo  = 4'b1111;

    // Multiply/divide sequencer states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative multiply/divide engine. Radix-2 shift-add multiply
//                and restoring divide, one bit per clock over WIDTH clocks.
//                Signed operations run on magnitudes. The sign fix-up is
//                applied combinationally to the final result, which is
//                presented on o_hi/o_lo while o_wr is high.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                i_start         - accepted mul/div start (already qualified)
//                i_is_div        - 1 = divide, 0 = multiply
//                i_is_signed     - 1 = signed operands
//                i_srca, i_srcb  - dividend/multiplicand, divisor/multiplier
//                o_busy          - operation in progress
//                o_done          - one-cycle pulse after HI/LO were written
//                o_wr            - write strobe for HI/LO (last RUN cycle)
//                o_hi, o_lo      - final HI/LO values, valid while o_wr
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_srca,
    input  logic [WIDTH-1:0] i_srcb,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_wr,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int                 c_cnt_w    = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;

    // r_p: partial product high half / partial remainder
    // r_q: multiplier (shifted out) / dividend (shifted out, quotient in)
    // r_m: multiplicand / divisor magnitude
    logic [WIDTH-1:0]   r_p;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_a;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_done;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_wr;

    assign w_a_neg = i_is_signed & i_srca[WIDTH-1];
    assign w_b_neg = i_is_signed & i_srcb[WIDTH-1];
    assign w_a_mag = w_a_neg ? -i_srca : i_srca;
    assign w_b_mag = w_b_neg ? -i_srcb : i_srcb;

    // ------------------------------------------------------------------
    // One iteration of each algorithm, evaluated from the current state
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mul_p;
    logic [WIDTH-1:0] w_mul_q;

    assign w_sum   = {1'b0, r_p} + (r_q[0] ? {1'b0, r_m} : '0);
    assign w_mul_p = w_sum[WIDTH:1];
    assign w_mul_q = {w_sum[0], r_q[WIDTH-1:1]};

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_div_p;
    logic [WIDTH-1:0] w_div_q;

    assign w_shift = {r_p, r_q[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_m});
    // The remainder is always below the divisor, so the low WIDTH bits of
    // the modular difference are exact whenever the subtraction is taken.
    assign w_sub   = w_shift[WIDTH-1:0] - r_m;
    assign w_div_p = w_ge ? w_sub : w_shift[WIDTH-1:0];
    assign w_div_q = {r_q[WIDTH-2:0], w_ge};

    // ------------------------------------------------------------------
    // Final result with sign correction. The -2^(W-1) / -1 case needs no
    // special handling: the magnitude quotient 2^(W-1) reads back as
    // -2^(W-1) in WIDTH bits and the remainder is 0.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_prod   = {w_mul_p, w_mul_q};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -w_div_q : w_div_q;
    assign w_rem    = r_neg_r ? -w_div_p : w_div_p;

    assign o_hi = r_div ? (r_dz ? r_a : w_rem)     : w_prod_s[2*WIDTH-1:WIDTH];
    assign o_lo = r_div ? (r_dz ? '1  : w_quo)     : w_prod_s[WIDTH-1:0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign w_wr = (r_state == RUN) && (r_cnt == c_cnt_one);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = RUN;
            RUN:     if (r_cnt == c_cnt_one) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_p     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_a     <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_wr;
            if (r_state == IDLE) begin
                if (i_start) begin
                    r_cnt   <= c_cnt_load;
                    r_p     <= '0;
                    r_q     <= w_a_mag;
                    r_m     <= w_b_mag;
                    r_a     <= i_srca;
                    r_div   <= i_is_div;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_dz    <= i_is_div && (i_srcb == '0);
                end
            end else begin
                r_cnt <= r_cnt - c_cnt_one;
                r_p   <= r_div ? w_div_p : w_mul_p;
                r_q   <= r_div ? w_div_q : w_mul_q;
            end
        end
    end

    assign o_busy = (r_state == RUN);
    assign o_done = r_done;
    assign o_wr   = w_wr;

endmodule : muldiv_seq
`default_nettype wire

// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mdu
//  Description : Execute-stage ALU with architectural HI/LO registers and an
//                iterative multiply/divide unit with a start/busy/done
//                handshake.
//  Ports       : clk, rst_n  - clock, asynchronous active-low reset
//                srcA, srcB  - operands (dividend/multiplicand, divisor/...)
//                ctrl        - 4-bit operation select
//                start       - qualifies MULT/MULTU/DIV/DIVU/MTHI/MTLO
//                aluResu     - combinational result
//                zero        - aluResu is all zeros
//                busy        - multiply/divide in progress
//                done        - one-cycle pulse after HI/LO update by mul/div
//                hi, lo      - HI/LO registers
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [3:0]       ctrl,
    input  logic             start,
    output logic [WIDTH-1:0] aluResu,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_res;

    logic             w_accept;
    logic             w_md_start;
    logic             w_is_div;
    logic             w_is_signed;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_md_wr;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_lo;

    // Any start seen while busy is dropped, MTHI/MTLO included.
    assign w_accept    = start & ~busy;
    assign w_md_start  = w_accept & ((ctrl == c_op_mult) | (ctrl == c_op_multu) |
                                     (ctrl == c_op_div)  | (ctrl == c_op_divu));
    assign w_is_div    = (ctrl == c_op_div)  | (ctrl == c_op_divu);
    assign w_is_signed = (ctrl == c_op_mult) | (ctrl == c_op_div);
    assign w_mthi      = w_accept & (ctrl == c_op_mthi);
    assign w_mtlo      = w_accept & (ctrl == c_op_mtlo);

    muldiv_seq #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_md_start),
        .i_is_div    (w_is_div),
        .i_is_signed (w_is_signed),
        .i_srca      (srcA),
        .i_srcb      (srcB),
        .o_busy      (busy),
        .o_done      (done),
        .o_wr        (w_md_wr),
        .o_hi        (w_md_hi),
        .o_lo        (w_md_lo)
    );

    // HI/LO: mul/div completion and MTHI/MTLO never coincide, because the
    // latter need busy low and completion happens only while busy is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_md_wr) begin
            r_hi <= w_md_hi;
            r_lo <= w_md_lo;
        end else begin
            if (w_mthi) r_hi <= srcA;
            if (w_mtlo) r_lo <= srcA;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

    // Combinational ALU
    always_comb begin
        w_res = '0;
        case (ctrl)
            c_op_add:   w_res = srcA + srcB;
            c_op_sub:   w_res = srcA - srcB;
            c_op_and:   w_res = srcA & srcB;
            c_op_or:    w_res = srcA | srcB;
            c_op_xor:   w_res = srcA ^ srcB;
            c_op_nor:   w_res = ~(srcA | srcB);
            c_op_slt:   w_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            c_op_sltu:  w_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            c_op_mfhi:  w_res = r_hi;
            c_op_mflo:  w_res = r_lo;
            c_op_mult,
            c_op_multu,
            c_op_div,
            c_op_divu,
            c_op_mthi,
            c_op_mtlo:  w_res = '0;
            default:    w_res = '0;
        endcase
    end

    assign aluResu = w_res;
    assign zero    = (w_res == '0);

endmodule : alu_mdu
`default_nettype wire
